// File: rtl/seg7_scan_ctrl.sv
// Four-digit BCD up/down counter driving a time-multiplexed 7-segment display.
// The counter steps on a prescaled tick; the display scans one digit per scan slot.
module seg7_scan_ctrl #(
  parameter int DIV_TICK = 12000000,
  parameter int DIV_SCAN = 12000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        up,
  input  logic        blank,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  output logic        g,
  output logic [3:0]  dig,
  output logic        wrap,
  output logic        err
);

  localparam int TW = (DIV_TICK > 2) ? $clog2(DIV_TICK) : 1;
  localparam int SW = (DIV_SCAN > 2) ? $clog2(DIV_SCAN) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(DIV_TICK - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(DIV_SCAN - 1);

  // Every nibble must be a decimal digit for a load to be accepted.
  function automatic logic bcd_valid(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // One decimal step with ripple carry/borrow; bit 16 is the carry/borrow out.
  function automatic logic [16:0] bcd_step(input logic [15:0] v, input logic inc);
    logic [15:0] r;
    logic        cy;
    r  = v;
    cy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (cy) begin
        if (inc) begin
          if (v[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            cy          = 1'b0;
          end
        end else begin
          if (v[4*i +: 4] == 4'd0) begin
            r[4*i +: 4] = 4'd9;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] - 4'd1;
            cy          = 1'b0;
          end
        end
      end
    end
    return {cy, r};
  endfunction

  // Segment pattern ordered {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] s;
    case (digit)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  logic [TW-1:0] tick_cnt, tick_cnt_nxt;
  logic [SW-1:0] scan_cnt, scan_cnt_nxt;
  logic [1:0]    dig_idx, dig_idx_nxt;
  logic [15:0]   count, count_nxt;
  logic [16:0]   step;
  logic          tick, load_ok, load_bad, scan_wrap;
  logic          wrap_nxt;
  logic [3:0]    cur_digit;
  logic [6:0]    seg_nxt;
  logic [3:0]    dig_nxt;
  logic [6:0]    seg_p1;
  logic [3:0]    dig_p1;
  logic          wrap_p1, err_p1;

  assign load_ok   = load && bcd_valid(load_val);
  assign load_bad  = load && !bcd_valid(load_val);
  assign tick      = en && (tick_cnt == TICK_MAX);
  assign step      = bcd_step(count, up);
  assign scan_wrap = (scan_cnt == SCAN_MAX);

  // Load (good or bad) takes precedence over a coincident tick.
  always_comb begin
    tick_cnt_nxt = tick_cnt;
    count_nxt    = count;
    wrap_nxt     = 1'b0;
    if (load_ok) begin
      count_nxt    = load_val;
      tick_cnt_nxt = '0;
    end else if (!load_bad && en) begin
      if (tick) begin
        tick_cnt_nxt = '0;
        count_nxt    = step[15:0];
        wrap_nxt     = step[16];
      end else begin
        tick_cnt_nxt = tick_cnt + 1'b1;
      end
    end
  end

  // Display stage is built from next-state values so digit and segments land together.
  always_comb begin
    scan_cnt_nxt = scan_wrap ? '0 : scan_cnt + 1'b1;
    dig_idx_nxt  = scan_wrap ? dig_idx + 2'd1 : dig_idx;
    cur_digit    = count_nxt[{dig_idx_nxt, 2'b00} +: 4];
    seg_nxt      = blank ? 7'b0 : seg_encode(cur_digit);
    dig_nxt      = blank ? 4'b0 : (4'b0001 << dig_idx_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      scan_cnt <= '0;
      dig_idx  <= 2'd0;
      count    <= 16'h0000;
      seg_p1   <= 7'b0;
      dig_p1   <= 4'b0;
      wrap_p1  <= 1'b0;
      err_p1   <= 1'b0;
    end else begin
      tick_cnt <= tick_cnt_nxt;
      scan_cnt <= scan_cnt_nxt;
      dig_idx  <= dig_idx_nxt;
      count    <= count_nxt;
      seg_p1   <= seg_nxt;
      dig_p1   <= dig_nxt;
      wrap_p1  <= wrap_nxt;
      err_p1   <= load_bad;
    end
  end

  assign {a, b, c, d, e, f, g} = seg_p1;
  assign dig  = dig_p1;
  assign wrap = wrap_p1;
  assign err  = err_p1;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a decimal-arithmetic reference model
// queues per-cycle expected outputs, and a negedge monitor compares them.
module tb_seg7_scan_ctrl;
  localparam int DIV_TICK = 4;
  localparam int DIV_SCAN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        up = 1'b1;
  logic        blank = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic        a, b, c, d, e, f, g;
  logic [3:0]  dig;
  logic        wrap, err;

  seg7_scan_ctrl #(.DIV_TICK(DIV_TICK), .DIV_SCAN(DIV_SCAN)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .blank(blank),
    .load(load), .load_val(load_val),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .dig(dig), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       wrap;
    logic       err;
  } exp_t;

  exp_t  sb_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    m_cnt = 0, m_tp = 0, m_sp = 0, m_idx = 0;
  int    m_wraps = 0, m_errs = 0, d_wraps = 0, d_errs = 0;
  string SEGS[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                      "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  function automatic logic [6:0] seg_of(input string s);
    logic [6:0] r;
    int k;
    r = '0;
    for (int i = 0; i < s.len(); i++) begin
      k = int'(s[i]) - 97;
      r[6-k] = 1'b1;
    end
    return r;
  endfunction

  function automatic bit all_decimal(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd_to_int(input logic [15:0] v);
    int s;
    s = 0;
    for (int i = 3; i >= 0; i--) s = s * 10 + int'(v[4*i +: 4]);
    return s;
  endfunction

  function automatic int digit_of(input int value, input int pos);
    int p;
    p = 1;
    repeat (pos) p = p * 10;
    return (value / p) % 10;
  endfunction

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: plain decimal arithmetic, sampled on every rising edge.
  initial begin : model
    exp_t ex;
    forever begin
      @(posedge clk);
      cyc++;
      ex.wrap = 1'b0;
      ex.err  = 1'b0;
      if (!rst_n) begin
        m_cnt = 0; m_tp = 0; m_sp = 0; m_idx = 0;
        ex.dig = 4'b0;
        ex.seg = 7'b0;
      end else begin
        if (load && all_decimal(load_val)) begin
          m_cnt = bcd_to_int(load_val);
          m_tp  = 0;
        end else if (load) begin
          ex.err = 1'b1;
        end else if (en) begin
          if (m_tp == DIV_TICK - 1) begin
            m_tp = 0;
            if (up) begin
              ex.wrap = (m_cnt == 9999);
              m_cnt   = (m_cnt + 1) % 10000;
            end else begin
              ex.wrap = (m_cnt == 0);
              m_cnt   = (m_cnt + 9999) % 10000;
            end
          end else begin
            m_tp++;
          end
        end
        if (m_sp == DIV_SCAN - 1) begin
          m_sp  = 0;
          m_idx = (m_idx + 1) % 4;
        end else begin
          m_sp++;
        end
        ex.dig = blank ? 4'b0 : 4'(1 << m_idx);
        ex.seg = blank ? 7'b0 : seg_of(SEGS[digit_of(m_cnt, m_idx)]);
      end
      if (ex.wrap) m_wraps++;
      if (ex.err)  m_errs++;
      sb_q.push_back(ex);
    end
  end

  initial begin : monitor
    exp_t ex;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        ex = sb_q.pop_front();
        chk("dig", {3'b0, dig}, {3'b0, ex.dig});
        chk("seg", {a, b, c, d, e, f, g}, ex.seg);
        chk("wrap", {6'b0, wrap}, {6'b0, ex.wrap});
        chk("err", {6'b0, err}, {6'b0, ex.err});
        if (wrap === 1'b1) d_wraps++;
        if (err === 1'b1)  d_errs++;
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1; en = 1'b1; up = 1'b1;
    step(13);
    // Wrap up from 9999, then down from 0000.
    load = 1'b1; load_val = 16'h9999; step(1); load = 1'b0;
    step(6);
    up = 1'b0;
    load = 1'b1; load_val = 16'h0000; step(1); load = 1'b0;
    step(6);
    up = 1'b1;
    // Rejected load, then a good load landing on a tick.
    load = 1'b1; load_val = 16'h12A4; step(1); load = 1'b0;
    step(2);
    for (int i = 0; i < DIV_TICK && m_tp != DIV_TICK - 1; i++) step(1);
    load = 1'b1; load_val = 16'h0199; step(1); load = 1'b0;
    step(3);
    // Two-digit carry, then let the scan sweep all digits.
    load = 1'b1; load_val = 16'h0109; step(1); load = 1'b0;
    step(10);
    blank = 1'b1; step(10); blank = 1'b0;
    step(4);
    // Reset mid-operation with a coincident load.
    load = 1'b1; load_val = 16'h0573; step(1); load = 1'b0;
    step(3);
    rst_n = 1'b0; load = 1'b1; step(1);
    rst_n = 1'b1; load = 1'b0;
    step(4);
    // Reset glitch between edges must be ignored.
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step(3);
    en = 1'b0; step(6); en = 1'b1;
    step(4);
    for (int i = 0; i < 2500; i++) begin
      en    = ($urandom_range(0, 9) != 0);
      up    = 1'($urandom_range(0, 1));
      blank = ($urandom_range(0, 15) == 0);
      load  = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 2))
        0: load_val = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                       4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        1: load_val = 16'($urandom);
        default: load_val = ($urandom_range(0, 1) != 0) ? 16'h9998 : 16'h0001;
      endcase
      rst_n = ($urandom_range(0, 299) != 0);
      step(1);
    end
    rst_n = 1'b1; load = 1'b0; blank = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
    end
    checks++;
    if (d_wraps != m_wraps) begin
      failures++;
      $display("FAIL wrap_count: got %0d pulses, expected %0d", d_wraps, m_wraps);
    end
    checks++;
    if (d_errs != m_errs) begin
      failures++;
      $display("FAIL err_count: got %0d pulses, expected %0d", d_errs, m_errs);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
